// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, queue
// depth, and opcode values the branch controller uses to request redirects.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } fetch_state_e;

  localparam int QUEUE_DEPTH = 2;

  // Redirect-producing opcodes of the branch controller
  localparam logic [4:0] OP_JR   = 5'b01101;
  localparam logic [4:0] OP_JPC  = 5'b01110;
  localparam logic [4:0] OP_BRFL = 5'b01111;
  localparam logic [4:0] OP_CALL = 5'b10000;
  localparam logic [4:0] OP_RET  = 5'b10001;

  // Words that will still be held after this cycle: queued entries not being
  // popped now, plus the response landing this cycle.
  function automatic logic [2:0] occupancy(input logic [1:0] count,
                                           input logic       pop,
                                           input logic       inflight);
    return {1'b0, count} - {2'b00, pop} + {2'b00, inflight};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of {pc, instr} with flush. Flush wins over push
// and pop; the head entry is presented combinationally from storage.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int AWIDTH = 15,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [AWIDTH-1:0] push_pc,
  input  logic [DWIDTH-1:0] push_instr,
  input  logic              pop,
  output logic [AWIDTH-1:0] head_pc,
  output logic [DWIDTH-1:0] head_instr,
  output logic [1:0]        count,
  output logic              empty,
  output logic              full
);

  logic [AWIDTH-1:0] pc_q    [QUEUE_DEPTH];
  logic [AWIDTH-1:0] pc_d    [QUEUE_DEPTH];
  logic [DWIDTH-1:0] instr_q [QUEUE_DEPTH];
  logic [DWIDTH-1:0] instr_d [QUEUE_DEPTH];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              pop_ok, push_ok;

  assign empty      = (count_q == 2'd0);
  assign full       = (count_q == 2'(QUEUE_DEPTH));
  assign count      = count_q;
  assign head_pc    = pc_q[rd_ptr_q];
  assign head_instr = instr_q[rd_ptr_q];

  // A push into a full queue only lands if the head leaves the same cycle
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Pointer, count and storage next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      pc_d[i]    = pc_q[i];
      instr_d[i] = instr_q[i];
    end
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) begin
        pc_d[wr_ptr_q]    = push_pc;
        instr_d[wr_ptr_q] = push_instr;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  // Queue registers, cleared asynchronously so the head reads zero in reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_q[i]    <= pc_d[i];
        instr_q[i] <= instr_d[i];
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, 1-cycle-latency imem requests, 2-entry output
// queue and epoch-based discard of wrong-path words on redirect.
// Optional: define FETCH_PERF_CNT_EN for saturating perf_fetched/perf_flushed.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 15,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [AWIDTH-1:0] imem_addr,
  input  logic [DWIDTH-1:0] imem_rdata,
  input  logic              imem_rvalid,
  input  logic              redirect,
  input  logic [DWIDTH-1:0] redirect_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] instr_out,
  output logic [AWIDTH-1:0] pc_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
`endif
);

  localparam logic [AWIDTH-1:0] RESET_PC_A = AWIDTH'(RESET_PC);

  fetch_state_e      state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0] tag_pc_q, tag_pc_d;
  logic              tag_epoch_q, tag_epoch_d;
  logic              epoch_q, epoch_d;
  logic              inflight_q, inflight_d;

  logic [1:0]        q_count;
  logic              q_empty, q_full;
  logic              pop, push, cap_ok, issue;
  logic              unused_bits;

  assign out_valid = ~q_empty;
  assign pop       = out_valid & out_ready;
  // Capacity counts the word in flight so a stalled consumer never loses one
  assign cap_ok    = (occupancy(q_count, pop, inflight_q) < 3'(QUEUE_DEPTH));
  // Stale-epoch, unsolicited, or redirect-cycle responses are dropped
  assign push      = imem_rvalid & inflight_q & (tag_epoch_q == epoch_q) & ~redirect;
  assign imem_addr = pc_q;

  assign unused_bits = ^{redirect_addr[DWIDTH-1:AWIDTH], q_full};

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_BOOT;
    else      state_q <= state_d;
  end

  // FSM next state: redirect always lands in RUN
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN:  state_d = cap_ok ? ST_RUN : ST_FULL;
        ST_FULL: state_d = cap_ok ? ST_RUN : ST_FULL;
        default: state_d = ST_BOOT;
      endcase
    end
  end

  // FSM output: issue a read only while running with room and no redirect
  always_comb begin
    issue = (state_q == ST_RUN) && cap_ok && !redirect;
  end

  assign imem_req = issue;

  // PC, epoch and in-flight tag next-state
  always_comb begin
    pc_d        = pc_q;
    epoch_d     = epoch_q;
    tag_pc_d    = tag_pc_q;
    tag_epoch_d = tag_epoch_q;
    inflight_d  = issue;
    if (redirect) begin
      pc_d    = redirect_addr[AWIDTH-1:0];
      epoch_d = ~epoch_q;
    end else if (issue) begin
      pc_d        = pc_q + AWIDTH'(1);
      tag_pc_d    = pc_q;
      tag_epoch_d = epoch_q;
    end
  end

  // PC, epoch and in-flight tag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC_A;
      epoch_q     <= 1'b0;
      tag_pc_q    <= '0;
      tag_epoch_q <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      epoch_q     <= epoch_d;
      tag_pc_q    <= tag_pc_d;
      tag_epoch_q <= tag_epoch_d;
      inflight_q  <= inflight_d;
    end
  end

  fetch_queue #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (push),
    .push_pc    (tag_pc_q),
    .push_instr (imem_rdata),
    .pop        (pop),
    .head_pc    (pc_out),
    .head_instr (instr_out),
    .count      (q_count),
    .empty      (q_empty),
    .full       (q_full)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;
  logic [32:0] flushed_sum;

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
  // Discarded words: queued entries not popped this cycle plus the one in flight
  assign flushed_sum  = {1'b0, perf_flushed_q} + 33'(occupancy(q_count, pop, inflight_q));

  // Saturating counter next-state
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_flushed_d = perf_flushed_q;
    if (pop && (perf_fetched_q != 32'hFFFF_FFFF)) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (redirect) begin
      perf_flushed_d = flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect, wrap-around,
// back-to-back redirects and mid-stream reset. Memory returns word = address.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DWIDTH = 32;
  localparam int AWIDTH = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req;
  logic [AWIDTH-1:0] imem_addr;
  logic [DWIDTH-1:0] imem_rdata = '0;
  logic              imem_rvalid = 1'b0;
  logic              redirect;
  logic [DWIDTH-1:0] redirect_addr;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] instr_out;
  logic [AWIDTH-1:0] pc_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_flushed;
`endif

  logic              inj = 1'b0;
  int                total = 0;
  int                bad = 0;
  logic [AWIDTH-1:0] log_pc [$];
  logic [DWIDTH-1:0] log_in [$];

  always #5 clk = ~clk;

  fetch_unit #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .RESET_PC(0)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_rvalid   (imem_rvalid),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .instr_out     (instr_out),
    .pc_out        (pc_out)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_flushed  (perf_flushed)
`endif
  );

  // Instruction memory: 1-cycle latency, data equals address; inj forces a
  // spurious response
  always @(posedge clk) begin
    imem_rvalid <= imem_req | inj;
    imem_rdata  <= DWIDTH'(imem_addr);
  end

  // Record every accepted entry, one line per transfer
  always @(negedge clk) begin
    #2;
    if (rst && out_valid && out_ready) begin
      log_pc.push_back(pc_out);
      log_in.push_back(instr_out);
      $display("xfer pc=%h instr=%h", pc_out, instr_out);
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_log(input int n);
    int k;
    k = 0;
    while (log_pc.size() < n && k < 60) begin
      nxt();
      #3;
      k++;
    end
    chk("wait_log", 64'(log_pc.size() >= n), 64'd1);
  endtask

  task automatic chk_log(input string tag, input int base, input int n);
    for (int i = 0; i < n && i < log_pc.size(); i++) begin
      logic [AWIDTH-1:0] e;
      e = AWIDTH'(base + i);
      chk({tag, "_pc"}, 64'(log_pc[i]), 64'(e));
      chk({tag, "_instr"}, 64'(log_in[i]), 64'(e));
    end
  endtask

  task automatic do_redirect(input logic [4:0] op, input logic [DWIDTH-1:0] tgt);
    redirect      = 1'b1;
    redirect_addr = tgt;
    $display("redirect op=%b target=%h", op, tgt);
  endtask

  task automatic clear_log();
    log_pc.delete();
    log_in.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; out_ready = 1'b1; redirect = 1'b0; redirect_addr = '0;
    repeat (3) nxt();
    #1;
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_instr", 64'(instr_out), 64'd0);
    chk("rst_pc", 64'(pc_out), 64'd0);

    // Release reset: one BOOT cycle, then streaming from address 0
    nxt(); rst = 1'b1; #1;
    chk("boot_req", 64'(imem_req), 64'd0);
    nxt(); #1;
    chk("r0_req", 64'(imem_req), 64'd1);
    chk("r0_addr", 64'(imem_addr), 64'd0);
    nxt(); #1;
    chk("r1_addr", 64'(imem_addr), 64'd1);
    chk("r1_valid", 64'(out_valid), 64'd0);
    nxt(); #1;
    chk("r2_valid", 64'(out_valid), 64'd1);
    chk("r2_pc", 64'(pc_out), 64'd0);
    chk("r2_instr", 64'(instr_out), 64'd0);
    chk("r2_addr", 64'(imem_addr), 64'd2);
    nxt(); nxt(); nxt(); #1;
    chk("r5_pc", 64'(pc_out), 64'd3);
    chk("r5_addr", 64'(imem_addr), 64'd5);

    // Stall for 5 cycles: queue fills, requests stop
    nxt(); out_ready = 1'b0; #1;
    chk("stall_req0", 64'(imem_req), 64'd0);
    for (int i = 0; i < 4; i++) begin
      nxt();
      inj = (i == 0);
      #1;
      chk("stall_req", 64'(imem_req), 64'd0);
    end
    inj = 1'b0;
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_pc", 64'(pc_out), 64'd4);
    nxt(); out_ready = 1'b1;
    wait_log(10);
    chk_log("stream", 0, 10);

    // Redirect with one entry queued and one word in flight
    nxt(); #1;
    chk("pre_redir_valid", 64'(out_valid), 64'd1);
    do_redirect(OP_CALL, 32'h0000_0100); #1;
    chk("redir_req", 64'(imem_req), 64'd0);
    nxt(); redirect = 1'b0; clear_log(); #1;
    chk("q1_valid", 64'(out_valid), 64'd0);
    chk("q1_addr", 64'(imem_addr), 64'h100);
    chk("q1_req", 64'(imem_req), 64'd1);
    nxt(); #1;
    chk("q2_valid", 64'(out_valid), 64'd0);
    chk("q2_addr", 64'(imem_addr), 64'h101);
    nxt(); #1;
    chk("q3_valid", 64'(out_valid), 64'd1);
    chk("q3_pc", 64'(pc_out), 64'h100);
    wait_log(3);
    chk_log("redir", 'h100, 3);

    // Wrap-around at the top of the address space
    nxt(); do_redirect(OP_JR, 32'h0000_7FFF); #1;
    nxt(); redirect = 1'b0; clear_log(); #1;
    chk("wrap_addr0", 64'(imem_addr), 64'h7FFF);
    nxt(); #1;
    chk("wrap_addr1", 64'(imem_addr), 64'h0000);
    wait_log(3);
    chk_log("wrap", 'h7FFF, 3);

    // Two redirects back to back: the second target wins
    nxt(); do_redirect(OP_JPC, 32'h0000_0010); #1;
    nxt(); do_redirect(OP_RET, 32'h0000_0020); clear_log(); #1;
    chk("b2b_req", 64'(imem_req), 64'd0);
    chk("b2b_valid", 64'(out_valid), 64'd0);
    nxt(); redirect = 1'b0; #1;
    chk("b2b_addr", 64'(imem_addr), 64'h20);
    wait_log(4);
    chk_log("b2b", 'h20, 4);

    // Reset pulse mid-stream
    nxt(); rst = 1'b0; #1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_req", 64'(imem_req), 64'd0);
    chk("mrst_pc", 64'(pc_out), 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("mrst_perf_fetched", 64'(perf_fetched), 64'd0);
    chk("mrst_perf_flushed", 64'(perf_flushed), 64'd0);
`endif
    nxt(); rst = 1'b1; clear_log(); #1;
    chk("mrst_boot_req", 64'(imem_req), 64'd0);
    nxt(); #1;
    chk("mrst_req1", 64'(imem_req), 64'd1);
    chk("mrst_addr", 64'(imem_addr), 64'd0);
    wait_log(3);
    chk_log("restart", 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
